// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks the 1-bit ALU slice across a W-bit word, LSB first.
// Optional build macro ALU_SEQ_SLT_EN adds set-less-than on op == 4'b0111.
module alu_serial_seq #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [3:0]   i_op,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_result,
   output logic         o_carry_out,
   output logic         o_overflow,
   output logic         o_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_res;
   logic [2:0]    r_op;
   logic [CW-1:0] r_cnt;
   logic          r_carry;
   logic          r_c_msb;

   logic          w_arith;
   logic          w_bsel;
   logic          w_sum;
   logic          w_bit;
   logic          w_carry_nxt;
   logic          w_last;
   logic          w_ovf_raw;
   logic [W-1:0]  w_res_final;
   logic          w_cout_final;
   logic          w_ovf_final;
   logic          w_unused;

   // op[3] only matters for the optional SLT decode
   assign w_unused = i_op[3];

   assign w_arith     = (r_op[1:0] == 2'b11) | r_op[2];
   assign w_bsel      = r_op[2] ? ~r_b[0] : r_b[0];
   assign w_sum       = r_a[0] ^ w_bsel ^ r_carry;
   assign w_carry_nxt = (r_a[0] & w_bsel) | (r_a[0] & r_carry) | (w_bsel & r_carry);
   assign w_last      = (r_cnt == CW'(W - 1));
   assign w_ovf_raw   = r_c_msb ^ r_carry;

   // One result bit for the current slice
   always_comb begin
      w_bit = w_sum;
      if (!w_arith) begin
         case (r_op[1:0])
            2'b00:   w_bit = r_a[0] & r_b[0];
            2'b01:   w_bit = r_a[0] | r_b[0];
            default: w_bit = r_a[0] ^ r_b[0];
         endcase
      end
   end

`ifdef ALU_SEQ_SLT_EN
   logic r_slt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_slt <= 1'b0;
      end else if (r_state == S_IDLE && i_start) begin
         r_slt <= (i_op == 4'b0111);
      end
   end

   // SLT: sign of the difference, corrected for signed overflow
   always_comb begin
      w_res_final  = r_res;
      w_cout_final = w_arith & r_carry;
      w_ovf_final  = w_arith & w_ovf_raw;
      if (r_slt) begin
         w_res_final  = W'(r_res[W-1] ^ w_ovf_raw);
         w_cout_final = 1'b0;
         w_ovf_final  = 1'b0;
      end
   end
`else
   always_comb begin
      w_res_final  = r_res;
      w_cout_final = w_arith & r_carry;
      w_ovf_final  = w_arith & w_ovf_raw;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_c_msb     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_result    <= '0;
         o_carry_out <= 1'b0;
         o_overflow  <= 1'b0;
         o_zero      <= 1'b0;
      end else begin
         o_busy <= (w_state_nxt == S_RUN);
         o_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_op    <= i_op[2:0];
                  r_cnt   <= '0;
                  r_carry <= i_op[2];
                  r_c_msb <= 1'b0;
               end
            end
            S_RUN: begin
               r_a   <= {1'b0, r_a[W-1:1]};
               r_b   <= {1'b0, r_b[W-1:1]};
               r_res <= {w_bit, r_res[W-1:1]};
               r_cnt <= r_cnt + CW'(1);
               if (w_arith) r_carry <= w_carry_nxt;
               if (w_last)  r_c_msb <= r_carry;
            end
            S_DONE: begin
               o_result    <= w_res_final;
               o_zero      <= (w_res_final == '0);
               o_carry_out <= w_cout_final;
               o_overflow  <= w_ovf_final;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq: scoreboarded results, latency, ignored starts, async reset.
module tb_alu_serial_seq;
   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   op;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   int           checks   = 0;
   int           failures = 0;
   exp_t         sb[$];
   logic [W-1:0] prev_res = '0;

   always #5 clk = ~clk;

   alu_serial_seq #(.W(W), .CW(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_a         (a),
      .i_b         (b),
      .i_op        (op),
      .o_busy      (busy),
      .o_done      (done),
      .o_result    (result),
      .o_carry_out (cout),
      .o_overflow  (ovf),
      .o_zero      (zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic, independent of the serial datapath
   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mop);
      exp_t       r;
      logic [8:0] s;
      logic [7:0] bb;
      r = '0;
      if (mop[1:0] == 2'b11 || mop[2]) begin
         bb    = mop[2] ? ~mb : mb;
         s     = {1'b0, ma} + {1'b0, bb} + 9'(mop[2]);
         r.res  = s[7:0];
         r.cout = s[8];
         r.ovf  = (ma[7] == bb[7]) && (s[7] != ma[7]);
`ifdef ALU_SEQ_SLT_EN
         if (mop == 4'b0111) begin
            r.res  = ($signed(ma) < $signed(mb)) ? 8'h01 : 8'h00;
            r.cout = 1'b0;
            r.ovf  = 1'b0;
         end
`endif
      end else begin
         case (mop[1:0])
            2'b00:   r.res = ma & mb;
            2'b01:   r.res = ma | mb;
            default: r.res = ma ^ mb;
         endcase
      end
      r.zero = (r.res == 8'h00);
      return r;
   endfunction

   // mode 0: plain op; 1: inject starts in RUN and DONE; 2: async reset at RUN cycle 4
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] top,
                         input int mode, input string tag);
      exp_t e;
      int   lat;
      int   nbusy;
      @(negedge clk);
      a = ta; b = tb_; op = top; start = 1'b1;
      sb.push_back(model(ta, tb_, top));
      @(posedge clk); #1;
      lat = 0; nbusy = 0;
      forever begin
         start = 1'b0;
         if (done) break;
         if (busy) nbusy++;
         if (lat == 4) begin
            chk({tag, "/hold"}, 32'(result), 32'(prev_res));
            if (mode == 2) begin
               #2 rst = 1'b1;
               #1;
               chk({tag, "/async_rst"}, 32'({busy, done, result, cout, ovf, zero}), 32'd0);
               sb.delete();
               prev_res = '0;
               @(posedge clk); #1;
               rst = 1'b0;
               return;
            end
         end
         if (mode == 1 && (lat == 3 || lat == 8)) begin
            a = ~a; b = 8'h55; op = 4'b0100; start = 1'b1;
         end
         if (lat >= 30) break;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(W + 1));
      chk({tag, "/busy_cycles"}, 32'(nbusy), 32'(W));
      chk({tag, "/sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, "/result"}, 32'(result), 32'(e.res));
      chk({tag, "/carry_out"}, 32'(cout), 32'(e.cout));
      chk({tag, "/overflow"}, 32'(ovf), 32'(e.ovf));
      chk({tag, "/zero"}, 32'(zero), 32'(e.zero));
      prev_res = e.res;
      @(posedge clk); #1;
      chk({tag, "/done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic idle_check(input string tag);
      int ndone;
      int nbusy;
      ndone = 0; nbusy = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
         if (busy) nbusy++;
      end
      chk({tag, "/no_done"}, 32'(ndone), 32'd0);
      chk({tag, "/no_busy"}, 32'(nbusy), 32'd0);
      chk({tag, "/result_kept"}, 32'(result), 32'(prev_res));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({busy, done, result, cout, ovf, zero}), 32'd0);
      rst = 1'b0;

      run_op(8'h7F, 8'h01, 4'b0011, 0, "add_ovf");
      run_op(8'h05, 8'h05, 4'b0100, 0, "sub_zero");
      run_op(8'h00, 8'h01, 4'b0100, 0, "sub_borrow");
      run_op(8'hF0, 8'h3C, 4'b0000, 0, "and");
      run_op(8'hF0, 8'h3C, 4'b0001, 0, "or");
      run_op(8'hF0, 8'h3C, 4'b0010, 0, "xor");
      run_op(8'hF0, 8'h3C, 4'b1000, 0, "and_op3");
      run_op(8'hFF, 8'h01, 4'b0111, 0, "op0111_a");
      run_op(8'h12, 8'h34, 4'b0011, 1, "ignore_start");
      idle_check("after_ignore");
      run_op(8'hF0, 8'h3C, 4'b0001, 2, "abort");
      run_op(8'hFE, 8'h01, 4'b0111, 0, "slt_neg");
      run_op(8'h01, 8'hFE, 4'b0111, 0, "slt_pos");
      run_op(8'h80, 8'h7F, 4'b0111, 0, "slt_ovf");
      for (int i = 0; i < 4; i++) begin
         run_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 0, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
